multicycle_control: RTL and testbench

- Multi-cycle successor to the single-cycle main control decoder.
- Sequences each MIPS instruction through fetch/decode/execute/memory/writeback states, sharing one ALU and one memory port.
- Adds a memory ready handshake, an optional access timeout, illegal-opcode trapping and a retired-instruction counter.
- Sits beside the datapath in the top level. Drives all datapath mux selects and write enables from opcode[31:26].

---
 rtl/multicycle_control.sv | 237 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: sequences each MIPS instruction through
// fetch/decode/execute/memory/writeback states over a shared ALU and a single
// memory port. It adds a memory ready handshake, an optional per-access
// timeout, illegal-opcode trapping and a retired-instruction counter.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   opcode[5:0]       instruction[31:26] from the IR
//   mem_ready         memory finished the current read/write this cycle
//   pc_write .. alu_src_a, alu_src_b, alu_op, pc_source   datapath controls
//   illegal_op        one-cycle pulse when an unsupported opcode traps
//   mem_fault         one-cycle pulse when a memory access times out
//   state_out[3:0]    current state encoding (debug)
//   instr_count       retired instructions, wraps modulo 2^COUNT_W
module multicycle_control #(
  parameter int MEM_TIMEOUT = 0,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1,
  parameter int COUNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               iord,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic               mem_fault,
  output logic [3:0]         state_out,
  output logic [COUNT_W-1:0] instr_count
);

  // Wide enough to hold 0..MEM_TIMEOUT.
  localparam int WC_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_TRAP      = 4'd12
  } state_e;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
    logic       mem_fault;
  } ctl_t;

  state_e             state_q, state_d;
  logic [WC_W-1:0]    wait_q, wait_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  ctl_t               c, c_out;
  logic               mem_state, timeout_hit, fault, retire;

  always_comb begin
    c           = '0;
    state_d     = state_q;
    wait_d      = '0;
    cnt_d       = cnt_q;
    fault       = 1'b0;
    retire      = 1'b0;
    mem_state   = (state_q inside {S_FETCH, S_MEM_READ, S_MEM_WRITE});
    // This waiting cycle is the MEM_TIMEOUT-th one in a row.
    timeout_hit = (MEM_TIMEOUT > 0) && (int'(wait_q) + 1 == MEM_TIMEOUT);

    // The counter only survives while stalled in a memory state; every
    // other cycle leaves the state, so it restarts at zero on any entry.
    if (mem_state && !mem_ready) begin
      if (timeout_hit) fault = 1'b1;
      else             wait_d = (wait_q == '1) ? wait_q : wait_q + 1'b1;
    end

    case (state_q)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.ir_write  = mem_ready;
        c.pc_write  = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        c.alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = ENABLE_ADDI ? S_ADDI_EXEC : S_TRAP;
          OP_J:         state_d = ENABLE_JUMP ? S_JUMP : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d     = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        c.mem_read = 1'b1;
        c.iord     = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        state_d      = S_FETCH;
        retire       = 1'b1;
      end
      S_MEM_WRITE: begin
        c.iord      = 1'b1;
        c.mem_write = !fault;   // an aborted store must not write
        if (mem_ready) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        state_d     = S_ALU_WB;
      end
      S_ALU_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        state_d         = S_FETCH;
        retire          = 1'b1;
      end
      S_JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = 2'b10;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        c.alu_op    = 2'b11;
        state_d     = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        c.reg_write = 1'b1;
        state_d     = S_FETCH;
        retire      = 1'b1;
      end
      S_TRAP: begin
        // PC was already advanced in FETCH; just resume there.
        c.illegal_op = 1'b1;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (fault) state_d = S_FETCH;
    c.mem_fault = fault;
    if (retire) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
    end
  end

  // Everything reads zero while reset is held, so an aborted instruction
  // cannot leak a write enable during the reset cycle.
  assign c_out         = reset ? '0 : c;
  assign pc_write      = c_out.pc_write;
  assign pc_write_cond = c_out.pc_write_cond;
  assign iord          = c_out.iord;
  assign mem_read      = c_out.mem_read;
  assign mem_write     = c_out.mem_write;
  assign ir_write      = c_out.ir_write;
  assign mem_to_reg    = c_out.mem_to_reg;
  assign reg_dst       = c_out.reg_dst;
  assign reg_write     = c_out.reg_write;
  assign alu_src_a     = c_out.alu_src_a;
  assign alu_src_b     = c_out.alu_src_b;
  assign alu_op        = c_out.alu_op;
  assign pc_source     = c_out.pc_source;
  assign illegal_op    = c_out.illegal_op;
  assign mem_fault     = c_out.mem_fault;
  assign state_out     = reset ? 4'd0 : state_q;
  assign instr_count   = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control. Two instances run side by side:
//   dut0: defaults (no timeout, addi and j decoded, 32-bit counter)
//   dut1: MEM_TIMEOUT=4, addi and j illegal, 4-bit counter (wraps)
// A per-instance model holds the current instruction as a list of states to
// walk; memory states only advance on mem_ready (or a timeout).
module tb_multicycle_control;

  logic            clk = 1'b0;
  logic            reset;
  logic [1:0][5:0] op;
  logic [1:0]      rdy;
  logic [1:0]      pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic [1:0]      mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, mem_fault;
  logic [1:0][1:0] alu_src_b, alu_op, pc_source;
  logic [1:0][3:0] so;
  logic [31:0]     ic0;
  logic [3:0]      ic1;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(0), .ENABLE_ADDI(1'b1), .ENABLE_JUMP(1'b1), .COUNT_W(32)) dut0 (
    .clk(clk), .reset(reset), .opcode(op[0]), .mem_ready(rdy[0]),
    .pc_write(pc_write[0]), .pc_write_cond(pc_write_cond[0]), .iord(iord[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]), .ir_write(ir_write[0]),
    .mem_to_reg(mem_to_reg[0]), .reg_dst(reg_dst[0]), .reg_write(reg_write[0]),
    .alu_src_a(alu_src_a[0]), .alu_src_b(alu_src_b[0]), .alu_op(alu_op[0]),
    .pc_source(pc_source[0]), .illegal_op(illegal_op[0]), .mem_fault(mem_fault[0]),
    .state_out(so[0]), .instr_count(ic0));

  multicycle_control #(.MEM_TIMEOUT(4), .ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0), .COUNT_W(4)) dut1 (
    .clk(clk), .reset(reset), .opcode(op[1]), .mem_ready(rdy[1]),
    .pc_write(pc_write[1]), .pc_write_cond(pc_write_cond[1]), .iord(iord[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]), .ir_write(ir_write[1]),
    .mem_to_reg(mem_to_reg[1]), .reg_dst(reg_dst[1]), .reg_write(reg_write[1]),
    .alu_src_a(alu_src_a[1]), .alu_src_b(alu_src_b[1]), .alu_op(alu_op[1]),
    .pc_source(pc_source[1]), .illegal_op(illegal_op[1]), .mem_fault(mem_fault[1]),
    .state_out(so[1]), .instr_count(ic1));

  // Bit positions inside the 18-bit control vector.
  localparam int B_PWC = 16, B_IORD = 15, B_MRD = 14, B_MWR = 13;
  localparam int B_M2R = 11, B_RDST = 10, B_RW = 9, B_ILL = 1, B_FLT = 0;

  int errs = 0, checks = 0;

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  task automatic chkb(input string nm, input int d, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0b expected %0b", nm, d, act, exp);
    end
  endtask

  function automatic logic [17:0] dctl(input int d);
    return {pc_write[d], pc_write_cond[d], iord[d], mem_read[d], mem_write[d], ir_write[d],
            mem_to_reg[d], reg_dst[d], reg_write[d], alu_src_a[d], alu_src_b[d], alu_op[d],
            pc_source[d], illegal_op[d], mem_fault[d]};
  endfunction

  function automatic logic [31:0] dcnt(input int d);
    return (d == 0) ? ic0 : {28'd0, ic1};
  endfunction

  // ---------------- behavioural model ----------------
  int          tmo[2]     = '{0, 4};
  bit          en_addi[2] = '{1'b1, 1'b0};
  bit          en_j[2]    = '{1'b1, 1'b0};
  int unsigned cmask[2]   = '{32'hFFFF_FFFF, 32'h0000_000F};
  int          plan[2][4];
  int          plen[2];
  int          pos[2];       // -1 = fetching, else index into plan
  int          waits[2];
  int unsigned mcnt[2];
  bit          run = 1'b0;

  function automatic int cur(input int d);
    return (pos[d] < 0) ? 0 : plan[d][pos[d]];
  endfunction

  // Remaining states of an instruction after DECODE.
  function automatic void build(input int d);
    plen[d] = 2;
    plan[d][1] = 12;
    case (op[d])
      6'b100011: begin plan[d][1] = 2; plan[d][2] = 3; plan[d][3] = 4; plen[d] = 4; end
      6'b101011: begin plan[d][1] = 2; plan[d][2] = 5; plen[d] = 3; end
      6'b000000: begin plan[d][1] = 6; plan[d][2] = 7; plen[d] = 3; end
      6'b000100: plan[d][1] = 8;
      6'b001000: if (en_addi[d]) begin plan[d][1] = 10; plan[d][2] = 11; plen[d] = 3; end
      6'b000010: if (en_j[d]) plan[d][1] = 9;
      default: ;
    endcase
  endfunction

  function automatic logic [17:0] ectl(input int st, input bit r, input bit f);
    logic pw = 0, pwc = 0, io = 0, mr = 0, mw = 0, ir = 0, mtr = 0, rd = 0, rw = 0, sa = 0, il = 0;
    logic [1:0] sb = 0, ao = 0, ps = 0;
    case (st)
      0:  begin mr = 1; sb = 2'b01; ir = r; pw = r; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; mtr = 1; end
      5:  begin mw = !f; io = 1; end
      6:  begin sa = 1; ao = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; ao = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin sa = 1; sb = 2'b10; ao = 2'b11; end
      11: rw = 1;
      12: il = 1;
      default: ;
    endcase
    return {pw, pwc, io, mr, mw, ir, mtr, rd, rw, sa, sb, ao, ps, il, f};
  endfunction

  // Compare every cycle, then advance the model to the next cycle.
  always @(negedge clk) begin
    if (run) begin
      for (int d = 0; d < 2; d++) begin
        int st;
        bit r, f, mem;
        st = cur(d);
        r  = rdy[d];
        if (reset) begin
          chk("rst_ctl", d, {14'd0, dctl(d)}, 32'd0);
          chk("rst_state", d, {28'd0, so[d]}, 32'd0);
          chk("rst_count", d, dcnt(d), 32'd0);
          pos[d] = -1; waits[d] = 0; mcnt[d] = 0;
        end else begin
          mem = (st == 0 || st == 3 || st == 5);
          f   = mem && !r && tmo[d] > 0 && (waits[d] + 1 == tmo[d]);
          chk("ctl", d, {14'd0, dctl(d)}, {14'd0, ectl(st, r, f)});
          chk("state", d, {28'd0, so[d]}, st);
          chk("count", d, dcnt(d), mcnt[d] & cmask[d]);
          if (mem && !r && !f) waits[d]++;
          else begin
            waits[d] = 0;
            if (f) pos[d] = -1;
            else if (pos[d] < 0) pos[d] = 0;
            else begin
              if (pos[d] == 0) build(d);
              if (pos[d] == plen[d] - 1) begin
                if (st != 12) mcnt[d]++;
                pos[d] = -1;
              end else pos[d]++;
            end
          end
        end
      end
    end
  end

  // ---------------- directed sequences ----------------
  int          sq[16];
  logic [17:0] cv[16];

  task automatic grab(input int d, input int i);
    @(negedge clk);
    sq[i] = so[d];
    cv[i] = dctl(d);
  endtask

  task automatic step(input int d, input bit r, input int i);
    @(posedge clk); #1;
    rdy[d] = r;
    grab(d, i);
  endtask

  function automatic logic [5:0] pick();
    case ($urandom_range(0, 7))
      0: return 6'b000000;
      1: return 6'b100011;
      2: return 6'b101011;
      3: return 6'b000100;
      4: return 6'b001000;
      5: return 6'b000010;
      6: return 6'($urandom_range(0, 63));
      default: return 6'b111111;
    endcase
  endfunction

  initial begin
    int icb;
    plan[0][0] = 1; plan[1][0] = 1;
    pos[0] = -1; pos[1] = -1;
    reset = 1'b1; op = '0; rdy = 2'b11;
    run = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 0, {28'd0, so[0]}, 32'd0);
    chk("reset_ctl", 1, {14'd0, dctl(1)}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0; op[0] = 6'b000000; rdy[1] = 1'b0;   // park dut1 in FETCH

    // R-type: 0,1,6,7,0
    begin
      int e[5] = '{0, 1, 6, 7, 0};
      grab(0, 0);
      for (int i = 1; i < 5; i++) step(0, 1'b1, i);
      for (int i = 0; i < 5; i++) begin
        chk("rtype_seq", 0, sq[i], e[i]);
        chkb("rtype_rw", 0, cv[i][B_RW], i == 3);
        chkb("rtype_rdst", 0, cv[i][B_RDST], i == 3);
      end
      chk("rtype_count", 0, ic0, 32'd1);
    end

    // lw with two wait cycles: 0,1,2,3,3,3,4,0
    #1 op[0] = 6'b100011;
    begin
      int e[8] = '{0, 1, 2, 3, 3, 3, 4, 0};
      bit r[8] = '{1, 1, 1, 0, 0, 1, 1, 1};
      for (int i = 1; i < 8; i++) step(0, r[i], i);
      for (int i = 1; i < 8; i++) begin
        chk("lw_seq", 0, sq[i], e[i]);
        chkb("lw_iord", 0, cv[i][B_IORD], i >= 3 && i <= 5);
        chkb("lw_rw", 0, cv[i][B_RW], i == 6);
        chkb("lw_m2r", 0, cv[i][B_M2R], i == 6);
      end
      chkb("lw_mrd", 0, cv[4][B_MRD], 1'b1);
      chk("lw_count", 0, ic0, 32'd2);
    end

    // beq: 1,8,0
    #1 op[0] = 6'b000100;
    for (int i = 1; i < 4; i++) step(0, 1'b1, i);
    chk("beq_seq", 0, sq[2], 32'd8);
    chk("beq_end", 0, sq[3], 32'd0);
    chkb("beq_pwc", 0, cv[2][B_PWC], 1'b1);
    chk("beq_aluop", 0, {30'd0, cv[2][5:4]}, 32'd1);
    chk("beq_pcsrc", 0, {30'd0, cv[2][3:2]}, 32'd1);
    chk("beq_count", 0, ic0, 32'd3);

    // illegal 111111: 1,12,0
    #1 op[0] = 6'b111111;
    for (int i = 1; i < 4; i++) step(0, 1'b1, i);
    chk("ill_seq", 0, sq[2], 32'd12);
    for (int i = 1; i < 4; i++) chkb("ill_pulse", 0, cv[i][B_ILL], i == 2);
    chk("ill_count", 0, ic0, 32'd3);

    // sw on dut1 with store never acknowledged: fault on 4th wait cycle
    #1 op[1] = 6'b101011;
    icb = ic1;
    begin
      int e[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
      bit r[8] = '{1, 1, 1, 0, 0, 0, 0, 0};
      for (int i = 0; i < 8; i++) step(1, r[i], i);
      for (int i = 0; i < 8; i++) begin
        chk("sw_seq", 1, sq[i], e[i]);
        chkb("sw_fault", 1, cv[i][B_FLT], i == 6);
        chkb("sw_mwr", 1, cv[i][B_MWR], i >= 3 && i <= 5);
      end
      chk("sw_count", 1, {28'd0, ic1}, icb);
    end

    // j with ENABLE_JUMP=0 traps: 0,1,12,0
    #1 op[1] = 6'b000010;
    icb = ic1;
    begin
      int e[4] = '{0, 1, 12, 0};
      for (int i = 0; i < 4; i++) step(1, 1'b1, i);
      for (int i = 0; i < 4; i++) begin
        chk("j_seq", 1, sq[i], e[i]);
        chkb("j_ill", 1, cv[i][B_ILL], i == 2);
      end
      chk("j_count", 1, {28'd0, ic1}, icb);
    end

    // reset while dut0 sits in ADDI_EXEC
    @(posedge clk); #1 rdy[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 op[0] = 6'b001000;
    step(0, 1'b1, 0);
    step(0, 1'b1, 1);
    chk("addi_decode", 0, sq[1], 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    grab(0, 2);
    chk("rstmid_ctl", 0, {14'd0, cv[2]}, 32'd0);
    chkb("rstmid_rw", 0, cv[2][B_RW], 1'b0);
    chk("rstmid_count", 0, ic0, 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    grab(0, 3);
    chk("rstmid_fetch", 0, sq[3], 32'd0);
    chk("rstmid_count2", 0, ic0, 32'd0);

    // randomized traffic: high then low ready rate, rare resets
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 299) == 0);
      for (int d = 0; d < 2; d++) begin
        rdy[d] = ($urandom_range(0, 99) < ((n < 1500) ? 85 : 40));
        if (cur(d) == 0) op[d] = pick();
      end
    end
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
